// File: rtl/mem_reader_pkg.sv
// Shared definitions for the memory dump reader: default word width and FSM encoding.
package mem_reader_pkg;

   localparam int MR_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET_A   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      FIN     = 3'd4
   } state_t;

endpackage

// File: rtl/mem_reader.sv
// Walks RAM from base for count words through the memory block's A register,
// presenting each (address, data) pair on a valid/ready output.
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int DATA_W = MR_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] base,
   input  logic [DATA_W-1:0] count,
   output logic              busy,
   output logic              done,
   output logic              m_storeA,
   output logic              m_storeD,
   output logic              m_store_ram,
   output logic [DATA_W-1:0] m_din,
   input  logic [DATA_W-1:0] m_outram,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] out_addr
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] remaining;
   logic              last;

   assign last = (remaining == DATA_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (count != '0) ? SET_A : FIN;
         SET_A:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = SEND;
         SEND:    if (out_ready) state_nxt = last ? FIN : SET_A;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // addr advances only on a non-final handshake, so out_addr always names the word sent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && count != '0) begin
                  addr      <= base;
                  remaining <= count;
               end
            end
            CAPTURE: begin
               out_data <= m_outram;
               out_addr <= addr;
            end
            SEND: begin
               if (out_ready && !last) begin
                  remaining <= remaining - DATA_W'(1);
                  addr      <= addr + DATA_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // All strobes decode straight from the state register so reset clears them at once
   assign busy        = (state != IDLE);
   assign done        = (state == FIN);
   assign out_valid   = (state == SEND);
   assign m_storeA    = (state == SET_A);
   assign m_din       = (state == SET_A) ? addr : '0;
   assign m_storeD    = 1'b0;
   assign m_store_ram = 1'b0;

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader with a behavioural A-register/RAM model.
module tb_mem_reader;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  base, count;
   logic          busy, done, m_storeA, m_storeD, m_store_ram;
   logic [W-1:0]  m_din, m_outram;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_data, out_addr;

   always #5 clk = ~clk;

   mem_reader #(.DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
      .busy(busy), .done(done), .m_storeA(m_storeA), .m_storeD(m_storeD),
      .m_store_ram(m_store_ram), .m_din(m_din), .m_outram(m_outram),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr)
   );

   // memory block: A register loaded by storeA, RAM[A] read combinationally
   logic [W-1:0] ram [0:65535];
   logic [W-1:0] a_reg = '0;
   always @(posedge clk) if (m_storeA) a_reg <= m_din;
   assign m_outram = ram[a_reg];

   int checks = 0;
   int fails  = 0;
   int done_cnt, storeA_cnt, valid_cnt;
   logic [2*W-1:0] got_q[$];
   logic [2*W-1:0] exp_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) got_q.push_back({out_addr, out_data});
         if (done)      done_cnt++;
         if (m_storeA)  storeA_cnt++;
         if (out_valid) valid_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      fails++;
      $display("FAIL %s: timeout waiting for done at %0t", name, $time);
   endtask

   task automatic clear_mon();
      got_q.delete();
      done_cnt = 0; storeA_cnt = 0; valid_cnt = 0;
   endtask

   // reference: a dump is the list of (base+i mod 2^W, RAM[base+i]) for i < count
   task automatic build_model(input logic [W-1:0] b, input logic [W-1:0] n);
      logic [W-1:0] a;
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         a = b + W'(i);
         exp_q.push_back({a, ram[a]});
      end
   endtask

   task automatic compare_words(input string name);
      check({name, "_nwords"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({name, "_word"}, got_q[i], exp_q[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [W-1:0] b, input logic [W-1:0] n, input logic rdy);
      @(posedge clk); #1;
      start = 1'b1; base = b; count = n; out_ready = rdy;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
      if (done_cnt == 0) timeout_fail(name);
   endtask

   task automatic run_dump(input logic [W-1:0] b, input logic [W-1:0] n, input int pct,
                           input string name);
      int cyc;
      build_model(b, n);
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; base = b; count = n;
      out_ready = ($urandom_range(99) < pct);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         out_ready = ($urandom_range(99) < pct);
         cyc++;
      end while (done_cnt == 0 && cyc < 2000);
      if (done_cnt == 0) timeout_fail(name);
      idle(2);
      out_ready = 1'b0;
      compare_words(name);
      check({name, "_done_once"}, done_cnt, 1);
      check({name, "_idle"}, busy, 1'b0);
   endtask

   typedef struct { logic sa; logic v; logic d; logic b; } trace_t;
   typedef struct { logic [W-1:0] b; logic [W-1:0] n; int pct; } dump_t;

   trace_t trace_tbl[11];
   dump_t  dump_tbl[5];

   initial begin
      // per-cycle expectation after the start edge for a 3-word dump with ready held high
      trace_tbl = '{
         '{1,0,0,1}, '{0,0,0,1}, '{0,1,0,1},
         '{1,0,0,1}, '{0,0,0,1}, '{0,1,0,1},
         '{1,0,0,1}, '{0,0,0,1}, '{0,1,0,1},
         '{0,0,1,1}, '{0,0,0,0}
      };
      dump_tbl = '{
         '{16'h0100, 16'd1, 100},
         '{16'h0200, 16'd5, 50},
         '{16'hFFFD, 16'd6, 70},
         '{16'h1234, 16'd4, 20},
         '{16'h8000, 16'd8, 100}
      };

      for (int i = 0; i < 65536; i++) ram[i] = W'($urandom);
      ram[5] = 16'd111; ram[6] = 16'd222; ram[7] = 16'd333;

      rst_n = 1'b0; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
      clear_mon();
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_storeA", m_storeA, 0);
      check("rst_buses", {out_data, out_addr}, 0);
      check("rst_din", m_din, 0);
      check("tied_stores", {m_storeD, m_store_ram}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // basic 3-word dump: exact cycle trace and payload
      clear_mon();
      pulse_start(16'd5, 16'd3, 1'b1);
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         check($sformatf("trace%0d", j), {m_storeA, out_valid, done, busy},
               {trace_tbl[j].sa, trace_tbl[j].v, trace_tbl[j].d, trace_tbl[j].b});
         if (j == 0) check("trace_din", m_din, 16'd5);
      end
      check("basic_n", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("basic_w0", got_q[0], {16'd5, 16'd111});
         check("basic_w1", got_q[1], {16'd6, 16'd222});
         check("basic_w2", got_q[2], {16'd7, 16'd333});
      end
      idle(2);

      // count == 0: straight to FIN
      clear_mon();
      pulse_start(16'd5, 16'd0, 1'b1);
      idle(4);
      check("zero_done", done_cnt, 1);
      check("zero_storeA", storeA_cnt, 0);
      check("zero_valid", valid_cnt, 0);

      // address wrap
      ram[16'hFFFF] = 16'd9; ram[0] = 16'd4;
      run_dump(16'hFFFF, 16'd2, 100, "wrap");
      if (got_q.size() == 2) begin
         check("wrap_w0", got_q[0], {16'hFFFF, 16'd9});
         check("wrap_w1", got_q[1], {16'h0000, 16'd4});
      end

      // 10-cycle stall in SEND
      clear_mon();
      pulse_start(16'd5, 16'd2, 1'b0);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      check("stall_valid_rise", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("stall_hold", {out_valid, out_addr, out_data}, {1'b1, 16'd5, 16'd111});
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done(50, "stall");
      idle(2);
      check("stall_n", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("stall_w0", got_q[0], {16'd5, 16'd111});
         check("stall_w1", got_q[1], {16'd6, 16'd222});
      end

      // start while busy is ignored
      clear_mon();
      build_model(16'd5, 16'd3);
      pulse_start(16'd5, 16'd3, 1'b1);
      idle(3);
      start = 1'b1; base = 16'd0; count = 16'd5;
      idle(1);
      start = 1'b0;
      wait_done(50, "busy_start");
      idle(20);
      check("busy_done", done_cnt, 1);
      check("busy_storeA", storeA_cnt, 3);
      compare_words("busy");

      // reset during CAPTURE of word 2 of 4
      clear_mon();
      pulse_start(16'd5, 16'd4, 1'b1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outs", {busy, done, out_valid, m_storeA}, 0);
      check("abort_buses", {out_data, out_addr, m_din}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(4);
      check("abort_no_done", done_cnt, 0);
      check("abort_words", got_q.size(), 1);
      run_dump(16'd5, 16'd1, 100, "post_rst");
      if (got_q.size() == 1) check("post_rst_w", got_q[0], {16'd5, 16'd111});

      // table of fixed dumps with random backpressure
      foreach (dump_tbl[i])
         run_dump(dump_tbl[i].b, dump_tbl[i].n, dump_tbl[i].pct, $sformatf("tbl%0d", i));

      // fully random dumps
      for (int i = 0; i < 20; i++)
         run_dump(W'($urandom), W'($urandom_range(1, 7)), $urandom_range(25, 100),
                  $sformatf("rnd%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
